// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scan sequencer for an 8:1 selector producing a parallel snapshot; W/Y cross-check enabled by MUX_WCHECK_EN
module mux_scan_ctrl #(
  parameter int SETTLE = 2,
  parameter int CNT_W = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] MASK,
  input  logic       Y,
  input  logic       W,
  output logic [2:0] A,
  output logic       G,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] DATA,
  output logic       ERR
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_FINISH} state_t;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       a_n;
  logic             g_n, busy_n, done_n, err_n;
  logic [7:0]       data_n, pend, pend_n, shadow, shadow_n, sh, pr;
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) lowest = 3'(i);
  endfunction
  // register every output together with the scan state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      cnt    <= '0;
      A      <= 3'd0;
      G      <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      DATA   <= 8'h00;
      ERR    <= 1'b0;
      pend   <= 8'h00;
      shadow <= 8'h00;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      A      <= a_n;
      G      <= g_n;
      BUSY   <= busy_n;
      DONE   <= done_n;
      DATA   <= data_n;
      ERR    <= err_n;
      pend   <= pend_n;
      shadow <= shadow_n;
    end
  end
  // next state; DONE/DATA are set on entry to FINISH so DONE is visible during FINISH
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    a_n      = A;
    g_n      = G;
    busy_n   = BUSY;
    done_n   = 1'b0;
    data_n   = DATA;
    err_n    = ERR;
    pend_n   = pend;
    shadow_n = shadow;
    sh       = shadow | ({7'd0, Y} << A);
    pr       = pend & ~(8'd1 << A);
    case (state)
      S_IDLE: begin
        g_n    = 1'b1;
        busy_n = 1'b0;
        if (START) begin
          err_n    = 1'b0;
          shadow_n = 8'h00;
          pend_n   = MASK;
          if (MASK != 8'h00) begin
            a_n     = lowest(MASK);
            g_n     = 1'b0;
            cnt_n   = CNT_INIT;
            busy_n  = 1'b1;
            state_n = S_SETTLE;
          end else begin
            done_n  = 1'b1;
            data_n  = 8'h00;
            state_n = S_FINISH;
          end
        end
      end
      S_SETTLE: begin
        cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
        state_n = cnt == '0 ? S_SAMPLE : S_SETTLE;
      end
      S_SAMPLE: begin
        shadow_n = sh;
        pend_n   = pr;
`ifdef MUX_WCHECK_EN
        err_n    = ERR | (W != ~Y);
`else
        err_n    = ERR & W & 1'b0;
`endif
        if (pr != 8'h00) begin
          a_n     = lowest(pr);
          g_n     = 1'b0;
          cnt_n   = CNT_INIT;
          state_n = S_SETTLE;
        end else begin
          g_n     = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          data_n  = sh;
          state_n = S_FINISH;
        end
      end
      default: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
    if (ABORT && state != S_IDLE) begin
      state_n  = S_IDLE;
      cnt_n    = cnt;
      a_n      = A;
      g_n      = 1'b1;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      data_n   = DATA;
      err_n    = ERR;
      pend_n   = pend;
      shadow_n = shadow;
    end
  end
endmodule
